// File: rtl/cla_pkg.sv
// Shared types for the multi-precision add/subtract sequencer.
package cla_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef struct packed {
    logic last;
    logic carry;
    logic ovf;
    logic err;
  } res_flags_t;

endpackage

// File: rtl/bit32cla.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups with group-level carry chain.
// Purely combinational; no flow control.
module bit32cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;

  always_comb begin
    logic cg;
    g    = a & b;
    p    = a ^ b;
    gg   = '0;
    gp   = '0;
    c    = '0;
    cg   = cin;
    for (int i = 0; i < 8; i++) begin
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gp[i] = &p[4*i +: 4];
      // in-group carries are looked ahead from the group's incoming carry
      c[4*i]   = cg;
      c[4*i+1] = g[4*i] | (p[4*i] & cg);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & cg);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & cg);
      cg       = gg[i] | (gp[i] & cg);
    end
    c[32] = cg;
    sum   = p ^ c[31:0];
    cout  = c[32];
  end

endmodule

// File: rtl/cla_mp_seq.sv
// Word-serial multi-precision add/sub around bit32cla, LS word first; 1-cycle latency, 1 word/cycle.
// Single-entry output register; in_ready drops while a result is stalled, holding all outputs.
module cla_mp_seq
  import cla_pkg::*;
#(
  parameter int MAX_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_sub,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_carry,
  output logic              out_ovf,
  output logic              out_err,
  output logic              busy
);

  localparam int            CW      = $clog2(MAX_WORDS);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WORDS - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic              carry_q;
  logic              sub_q;
  logic              accept;
  logic              first;
  logic              sub_eff;
  logic              cin;
  logic              is_last;
  logic [WORD_W-1:0] b_eff;
  logic [WORD_W-1:0] sum;
  logic              cout;
  res_flags_t        flags_q;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign first    = (state_q == IDLE);
  // the first word of an operation carries its own mode and seeds cin with it
  assign sub_eff  = first ? in_sub : sub_q;
  assign cin      = first ? in_sub : carry_q;
  assign b_eff    = sub_eff ? ~in_b : in_b;
  assign is_last  = in_last || (cnt_q == CNT_MAX);

  bit32cla u_add (
    .a    (in_a),
    .b    (b_eff),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = is_last ? IDLE : RUN;
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
    end else if (accept) begin
      if (first) sub_q <= in_sub;
      if (is_last) begin
        cnt_q   <= '0;
        carry_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_q + CW'(1);
        carry_q <= cout;
      end
    end
  end

  // flags stay zero on non-final words so the consumer can OR them blindly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      flags_q   <= '0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_sum       <= sum;
      flags_q.last  <= is_last;
      flags_q.carry <= is_last && cout;
      flags_q.ovf   <= is_last && (in_a[WORD_W-1] == b_eff[WORD_W-1])
                               && (sum[WORD_W-1] != in_a[WORD_W-1]);
      flags_q.err   <= is_last && !in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_last  = flags_q.last;
  assign out_carry = flags_q.carry;
  assign out_ovf   = flags_q.ovf;
  assign out_err   = flags_q.err;

endmodule

// File: tb/tb_cla_mp_seq.sv
// Directed bench for cla_mp_seq (MAX_WORDS=4) with a scoreboard of hand-computed results.
module tb_cla_mp_seq;

  localparam int MW = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic        last;
    logic        carry;
    logic        ovf;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        out_last;
  logic        out_carry;
  logic        out_ovf;
  logic        out_err;
  logic        busy;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cla_mp_seq #(.MAX_WORDS(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_err   (out_err),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic l, c, o, e);
    exp_t r;
    r.sum = s; r.last = l; r.carry = c; r.ovf = o; r.err = e;
    return r;
  endfunction

  // scoreboard pop: a handshake seen at the negedge completes on the next posedge
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_output observed=%h expected=none", out_sum);
      end else begin
        e = sb.pop_front();
        chk("out_word", {28'h0, out_sum, out_last, out_carry, out_ovf, out_err},
            {28'h0, e.sum, e.last, e.carry, e.ovf, e.err});
      end
    end
  end

  task automatic send(input logic [31:0] a, b, input logic s, l, input logic track, input exp_t e);
    in_a = a; in_b = b; in_sub = s; in_last = l; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        if (track) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $error("FAIL send_timeout observed=in_ready_low expected=accept");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("reset_outputs", {out_valid, busy, out_last, out_carry, out_ovf, out_err, out_sum}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // 64-bit add with carry across words
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, mk(32'h00000000, 0, 0, 0, 0));
    chk("t1_busy_mid", busy, 1);
    send(32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b1, mk(32'h00000001, 1, 0, 0, 0));
    chk("t1_valid_last", {out_valid, out_last}, 2'b11);
    chk("t1_busy_end", busy, 0);
    drain();

    // single-word subtract with borrow
    send(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b1, mk(32'hFFFFFFFE, 1, 0, 0, 0));
    chk("t2_busy", busy, 0);
    drain();

    // signed overflow, add and subtract
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b1, mk(32'h80000000, 1, 0, 1, 0));
    send(32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1, mk(32'h7FFFFFFF, 1, 1, 1, 0));
    drain();

    // backpressure during a 3-word add
    out_ready = 1'b0;
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, mk(32'h00000000, 0, 0, 0, 0));
    fork
      send(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, mk(32'h00000000, 0, 0, 0, 0));
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_hold", {out_valid, out_last, out_sum}, {2'b10, 32'h00000000});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    send(32'h00000001, 32'h00000002, 1'b0, 1'b1, 1'b1, mk(32'h00000004, 1, 0, 0, 0));
    drain();

    // truncation at MAX_WORDS, fifth word restarts with cin from in_sub
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, mk(32'h00000000, 0, 0, 0, 0));
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, mk(32'h00000001, 0, 0, 0, 0));
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, mk(32'h00000001, 0, 0, 0, 0));
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, mk(32'h00000001, 1, 1, 0, 1));
    chk("trunc_busy_cleared", busy, 0);
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, mk(32'h00000000, 0, 0, 0, 0));
    chk("trunc_restart_busy", busy, 1);
    send(32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b1, mk(32'h00000001, 1, 0, 0, 0));
    drain();

    // reset mid-operation drops pending word and stale carry
    out_ready = 1'b0;
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, mk(32'h0, 0, 0, 0, 0));
    chk("pre_reset_pending", {out_valid, busy}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {out_valid, busy, out_last, out_carry, out_ovf, out_err, out_sum}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b1, mk(32'h00000002, 1, 0, 0, 0));
    chk("post_reset_busy", busy, 0);

    for (int n = 0; n < 20; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cla_mp_seq.md
Name: cla_mp_seq

Overview:
- Multi-precision add/subtract sequencer around the team's 32-bit carry-lookahead adder (bit32cla).
- Accepts an operand pair as a word-serial stream, least-significant word first, one 32-bit word pair per handshake.
- Drives one bit32cla instance per word and chains the carry between words in a register.
- Emits the result stream with final carry, signed overflow and length-error flags; sits between a word-serial operand source and any downstream consumer (ALU, crypto/bignum datapath).

Parameters:
- MAX_WORDS, 8, maximum words per operation (≥2); counter width is clog2(MAX_WORDS).
- WORD_W, 32, word width; fixed by bit32cla, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand word pair valid.
- in_ready  out  1  sequencer can accept a word pair.
- in_a  in  32  operand A word.
- in_b  in  32  operand B word.
- in_sub  in  1  1 = A−B, 0 = A+B; sampled on the first word of an operation only.
- in_last  in  1  marks the most-significant word.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts the result word.
- out_sum  out  32  result word.
- out_last  out  1  final word of the operation.
- out_carry  out  1  carry-out of the final word; for subtract, 1 = no borrow. Meaningful only when out_last=1, else 0.
- out_ovf  out  1  signed two's-complement overflow of the full-width result. Meaningful only when out_last=1, else 0.
- out_err  out  1  operation truncated at MAX_WORDS. Meaningful only when out_last=1, else 0.
- busy  out  1  operation in progress: at least one word accepted, last word not yet accepted.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid, out_sum, out_last, out_carry, out_ovf, out_err, busy are 0.
  - Internal: carry register 0, word counter 0, sub latch 0, state IDLE.
  - in_ready is 1 in the first cycle after deassertion.
- States:
  - IDLE: expecting first word.
  - RUN: expecting a subsequent word.
- Accept: fires when in_valid && in_ready.
  - IDLE accept: latch sub=in_sub; adder cin=in_sub.
  - RUN accept: adder cin=carry register; in_sub is ignored.
- Datapath:
  - Adder inputs are in_a and (sub ? ~in_b : in_b).
  - Result is registered into out_sum; cout goes into the carry register.
- Latency and throughput:
  - Latency from accept to out_valid is 1 cycle.
  - Throughput is 1 word/cycle.
- Output buffer: single entry. in_ready = !out_valid || out_ready, so a same-cycle output pop and input push is allowed. While out_valid && !out_ready, all out_* fields are held stable.
- Last-word condition: in_last=1, or word counter == MAX_WORDS−1.
- On accepting the last word:
  - Set out_last=1.
  - out_carry = cout.
  - out_ovf = (a[31] == b_eff[31]) && (sum[31] != a[31]).
  - out_err = (!in_last), i.e. truncated.
  - Then clear counter and carry register, and go to IDLE.
- On accepting a non-last word: counter+1, state RUN, busy=1.
- A single-word operation (in_last on the first word) goes IDLE→IDLE. busy stays 0.
- Truncation: the word that would have been word MAX_WORDS+1 starts a new operation. Its in_sub is re-sampled.
- Reset mid-operation: all partial state is discarded; any pending output word is dropped and not delivered.
- Input fields are ignored when in_valid=0.

Decomposition:
- Shared package cla_pkg:
  - WORD_W=32 constant.
  - State typedef {IDLE, RUN}.
  - Result-flag struct {last, carry, ovf, err}.
- One sub-module: bit32cla instantiated unchanged as the word adder.
- Counter, FSM and output register stay in cla_mp_seq.

Test Plan:
- 64-bit add, out_ready=1: (A=FFFFFFFF, B=00000001), then (00000000, 00000000, last). Expect 00000000 then 00000001 (out_last=1, carry=0, ovf=0, err=0), on consecutive cycles.
- Single-word sub: A=00000005, B=00000007, sub=1, last. Expect FFFFFFFE, carry=0, ovf=0.
- Signed overflow: A=7FFFFFFF, B=00000001, add, last. Expect 80000000, ovf=1, carry=0. Then A=80000000, B=00000001, sub. Expect 7FFFFFFF, ovf=1, carry=1.
- Backpressure: out_ready=0 for 3 cycles during a 3-word add. Expect in_ready=0 and out_sum held stable. Release gives the full sequence with no loss or duplication, and the carry chain stays intact.
- Truncation with MAX_WORDS=4: stream 5 words of (FFFFFFFF, 00000001), no last.
  - Word 4 output has out_last=1, err=1, carry=1.
  - Word 5 restarts with cin=0, giving output 00000000 and carry register 1.
- Reset mid-op: assert rst_n=0 after word 1 of a 2-word add whose word 1 produced carry=1.
  - All outputs are 0 immediately.
  - After release, single-word 00000001+00000001 gives 00000002; the stale carry is not applied.
